// File: rtl/ser_inf_mch.sv
// Multi-channel parallel/serial exchange engine for BIST SDI/SDO chains.
// One channel is active per transaction; the bit order and the bit period are programmable.
module ser_inf_mch #(
    parameter int DW    = 32,
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_wr,
    input  logic             reg_rd,
    input  logic [CH_W-1:0]  reg_ch,
    input  logic             reg_msb_first,
    input  logic [DIV_W-1:0] reg_clk_div,
    input  logic [DW-1:0]    reg_wdata,
    output logic [DW-1:0]    reg_rdata,
    output logic             reg_ack,
    output logic             reg_err,
    output logic             reg_busy,
    output logic [NCH-1:0]   sdi,
    output logic [NCH-1:0]   shift,
    input  logic [NCH-1:0]   sdo
);

    localparam int BC_W = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q;
    logic              msb_q;
    logic              rd_q;
    logic              err_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [DW-1:0]     sreg;
    logic [DW-1:0]     cap;
    logic [DW-1:0]     cap_nxt;
    logic [DW-1:0]     rdata_q;
    logic              req;
    logic              ch_ok;
    logic              bit_end;
    logic              last_bit;
    logic              sdo_bit;
    logic              sdi_bit;

    assign req      = reg_wr | reg_rd;
    assign ch_ok    = 32'(reg_ch) < 32'(NCH);
    assign bit_end  = (div_cnt == '0);
    assign last_bit = bit_end && (bit_cnt == BC_W'(DW - 1));
    assign sdi_bit  = msb_q ? sreg[DW-1] : sreg[0];
    assign reg_rdata = rdata_q;

    always_comb begin
        sdo_bit = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_q == CH_W'(i)) sdo_bit = sdo[i];
        end
    end

    // Shifting toward the far end puts capture bit k at index k (LSB) or DW-1-k (MSB).
    assign cap_nxt = msb_q ? {cap[DW-2:0], sdo_bit} : {sdo_bit, cap[DW-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ch_ok ? SHIFT : DONE;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_ack  = (state_q == DONE);
        reg_err  = (state_q == DONE) && err_q;
        reg_busy = (state_q == SHIFT);
        shift    = '0;
        sdi      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (state_q == SHIFT && ch_q == CH_W'(i)) begin
                shift[i] = 1'b1;
                sdi[i]   = sdi_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q    <= '0;
            msb_q   <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            div_q   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            cap     <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        ch_q    <= reg_ch;
                        msb_q   <= reg_msb_first;
                        rd_q    <= reg_rd;
                        err_q   <= !ch_ok;
                        div_q   <= reg_clk_div;
                        div_cnt <= reg_clk_div;
                        bit_cnt <= '0;
                        sreg    <= reg_wr ? reg_wdata : '0;
                        cap     <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= div_q;
                        bit_cnt <= bit_cnt + BC_W'(1);
                        cap     <= cap_nxt;
                        sreg    <= msb_q ? (sreg << 1) : (sreg >> 1);
                        // The final sample lands in the same edge that moves to DONE.
                        if (last_bit && rd_q) rdata_q <= cap_nxt;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_inf_mch.sv
// Directed bench for ser_inf_mch: table of transactions plus handshake, invalid-channel
// and reset-abort sequences.
module tb_ser_inf_mch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_wr, reg_rd, reg_msb_first;
    logic [1:0]  reg_ch;
    logic [3:0]  reg_clk_div;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack, reg_err, reg_busy;
    logic [3:0]  sdi, shift, sdo;

    logic        wr3, rd3;
    logic [31:0] rdata3;
    logic        ack3, err3, busy3;
    logic [2:0]  sdi3, shift3;
    logic [2:0]  sdo3 = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ser_inf_mch dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_ch(reg_ch),
        .reg_msb_first(reg_msb_first), .reg_clk_div(reg_clk_div), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err), .reg_busy(reg_busy),
        .sdi(sdi), .shift(shift), .sdo(sdo)
    );

    ser_inf_mch #(.DW(32), .NCH(3), .CH_W(2), .DIV_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .reg_wr(wr3), .reg_rd(rd3), .reg_ch(reg_ch),
        .reg_msb_first(reg_msb_first), .reg_clk_div(reg_clk_div), .reg_wdata(reg_wdata),
        .reg_rdata(rdata3), .reg_ack(ack3), .reg_err(err3), .reg_busy(busy3),
        .sdi(sdi3), .shift(shift3), .sdo(sdo3)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  ch;
        logic        msb;
        logic [3:0]  div;
        logic [31:0] wdata;
        logic [31:0] sdo_word;
        logic        loopback;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [31:0] w, input int idx);
        if (idx < 0 || idx > 31) return 1'b0;
        return w[idx[4:0]];
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int   n = 0;
        int   j;
        int   p = int'(v.div) + 1;
        int   shifts = 0, sdi_err = 0, iso_err = 0, busy_err = 0;
        logic got_ack = 1'b0;
        logic exp_bit;
        logic [3:0] other;
        @(negedge clk);
        reg_wr = v.wr; reg_rd = v.rd; reg_ch = v.ch; reg_msb_first = v.msb;
        reg_clk_div = v.div; reg_wdata = v.wdata; sdo = '0;
        while (!got_ack && n < 600) begin
            @(negedge clk);
            n++;
            if (reg_ack) begin
                got_ack = 1'b1;
                reg_wr = 1'b0; reg_rd = 1'b0;
                check($sformatf("v%0d_rdata", id), reg_rdata, v.exp_rdata);
                check($sformatf("v%0d_err", id), 32'(reg_err), 32'd0);
            end else begin
                j = (n - 1) / p;
                if (shift[v.ch]) shifts++;
                if (!reg_busy) busy_err++;
                exp_bit = v.wr ? bit_of(v.wdata, v.msb ? 31 - j : j) : 1'b0;
                if (sdi[v.ch] !== exp_bit) sdi_err++;
                other = ~(4'b0001 << v.ch);
                if (((shift | sdi) & other) != 4'b0000) iso_err++;
                sdo = '0;
                sdo[v.ch] = v.loopback ? sdi[v.ch] : bit_of(v.sdo_word, v.msb ? 31 - j : j);
            end
        end
        sdo = '0;
        check($sformatf("v%0d_ack_seen", id), 32'(got_ack), 32'd1);
        check($sformatf("v%0d_latency", id), 32'(n), 32'(v.exp_lat));
        check($sformatf("v%0d_shift_cycles", id), 32'(shifts), 32'(32 * p));
        check($sformatf("v%0d_sdi_bits_wrong", id), 32'(sdi_err), 32'd0);
        check($sformatf("v%0d_idle_ch_activity", id), 32'(iso_err), 32'd0);
        check($sformatf("v%0d_busy_drops", id), 32'(busy_err), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] w0;
        logic got;

        vecs[0] = '{1'b1, 1'b0, 2'd1, 1'b0, 4'd0,  32'h0000_00F3, 32'h0,          1'b0, 33,  32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'd0,  32'h0,          32'hDEAD_BEEF, 1'b0, 33,  32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 1'b1, 4'd3,  32'h8000_0001, 32'h0,          1'b1, 129, 32'h8000_0001};
        vecs[3] = '{1'b0, 1'b1, 2'd3, 1'b1, 4'd1,  32'h0,          32'h1234_5678, 1'b0, 65,  32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'd15, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 1'b0, 513, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 2'd3, 1'b0, 4'd0,  32'hFFFF_0000, 32'h0,          1'b1, 33,  32'hFFFF_0000};

        rst_n = 1'b0;
        reg_wr = 1'b0; reg_rd = 1'b0; reg_ch = '0; reg_msb_first = 1'b0;
        reg_clk_div = '0; reg_wdata = '0; sdo = '0; wr3 = 1'b0; rd3 = 1'b0;
        #1;
        check("rst_rdata", reg_rdata, 32'h0);
        check("rst_sdi_shift", {24'h0, sdi, shift}, 32'h0);
        check("rst_ack_err_busy", {29'h0, reg_ack, reg_err, reg_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Invalid channel on the 3-channel instance.
        @(negedge clk);
        reg_ch = 2'd3; reg_wdata = 32'hFFFF_FFFF; wr3 = 1'b1;
        @(negedge clk);
        check("inv_ack_err", {30'h0, ack3, err3}, 32'h3);
        check("inv_shift", 32'(shift3), 32'h0);
        check("inv_rdata", rdata3, 32'h0);
        wr3 = 1'b0;
        @(negedge clk);
        check("inv_ack_after", {30'h0, ack3, busy3}, 32'h0);

        // Back-to-back write with mid-transfer input changes.
        @(negedge clk);
        w0 = 32'h0000_00A5;
        reg_wr = 1'b1; reg_rd = 1'b0; reg_ch = 2'd1; reg_msb_first = 1'b0;
        reg_clk_div = 4'd0; reg_wdata = w0;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                reg_wdata = 32'hFFFF_FFFF; reg_ch = 2'd2; reg_clk_div = 4'd7;
            end
            if (reg_ack) got = 1'b1;
            else if (shift !== 4'b0010 || sdi[1] !== bit_of(w0, n - 1)) begin
                check("b2b_first_stream", {24'h0, shift, sdi}, {24'h0, 4'b0010, 3'b000, bit_of(w0, n - 1), 1'b0});
            end
        end
        check("b2b_first_latency", 32'(n), 32'd33);
        @(negedge clk);
        check("b2b_idle_gap", {30'h0, reg_busy, reg_ack}, 32'h0);
        @(negedge clk);
        reg_wr = 1'b0;
        check("b2b_second_start", {27'h0, reg_busy, shift}, {27'h0, 1'b1, 4'b0100});
        check("b2b_second_sdi", 32'(sdi), 32'h4);
        n = 1; got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (reg_ack) got = 1'b1;
        end
        check("b2b_second_latency", 32'(n), 32'd257);
        check("b2b_rdata_kept", reg_rdata, 32'hFFFF_0000);

        // Reset in the middle of a read.
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b1; reg_ch = 2'd1; reg_msb_first = 1'b0;
        reg_clk_div = 4'd0; reg_wdata = '0;
        for (int k = 0; k < 11; k++) @(negedge clk);
        check("abort_busy_before", 32'(reg_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_sdi_shift", {24'h0, sdi, shift}, 32'h0);
        check("abort_ack_busy", {30'h0, reg_ack, reg_busy}, 32'h0);
        check("abort_rdata", reg_rdata, 32'h0);
        reg_rd = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (reg_ack) got = 1'b1;
        end
        check("abort_no_ack", 32'(got), 32'd0);
        rst_n = 1'b1;
        run_vec(6, '{1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 32'h0, 32'h0F0F_1234, 1'b0, 33, 32'h0F0F_1234});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
